// File: rtl/mem_arbiter_if.sv
// Signal bundle between the core, the memory arbiter and the external RAM bus.
// The slave modport is the arbiter's view; master is the core/RAM environment.
interface mem_arbiter_if;
    // Instruction fetch side
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    // Data load/store side
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_ben;
    logic [31:0] d_rdata;
    logic        d_ready;
    // External RAM bus
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_ben;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_rdata;
    logic        bus_busy;
    // Core status
    logic        freeze;
    logic        err;

    modport slave (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_ben,
        input  bus_rdata, bus_busy,
        output i_rdata, i_ready, d_rdata, d_ready,
        output bus_addr, bus_wdata, bus_ben, bus_ren, bus_wen,
        output freeze, err
    );

    modport master (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_ben,
        output bus_rdata, bus_busy,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  bus_addr, bus_wdata, bus_ben, bus_ren, bus_wen,
        input  freeze, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the core's single memory port between instruction fetch and data
// load/store. Data wins over fetch because it belongs to the instruction in
// flight. Each access is held on the bus until bus_busy drops or the wait
// counter reaches TIMEOUT-1, in which case the access is aborted with err.
module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    mif
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               d_req;
    logic               start_d;
    logic               start_i;
    logic               done;
    logic               abort;

    assign d_req = mif.d_read | mif.d_write;

    // A requester whose ready is high has just been served, so it does not stall.
    assign mif.freeze = (d_req & ~mif.d_ready) | (mif.i_req & ~mif.i_ready);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: arbitration in IDLE, completion/timeout detection in an access
    always_comb begin
        state_nxt = state;
        start_d   = 1'b0;
        start_i   = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !mif.d_ready) begin
                    state_nxt = DATA;
                    start_d   = 1'b1;
                end else if (mif.i_req && !mif.i_ready) begin
                    state_nxt = FETCH;
                    start_i   = 1'b1;
                end
            end
            FETCH, DATA: begin
                if (!mif.bus_busy) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter: counts busy cycles of the current access, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == IDLE || done || abort)
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + 1'b1;
    end

    // Bus launch, read-data capture and one-cycle ready/err pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mif.bus_addr  <= '0;
            mif.bus_wdata <= '0;
            mif.bus_ben   <= '0;
            mif.bus_ren   <= 1'b0;
            mif.bus_wen   <= 1'b0;
            mif.i_rdata   <= '0;
            mif.d_rdata   <= '0;
            mif.i_ready   <= 1'b0;
            mif.d_ready   <= 1'b0;
            mif.err       <= 1'b0;
        end else begin
            mif.i_ready <= 1'b0;
            mif.d_ready <= 1'b0;
            mif.err     <= 1'b0;
            if (start_d) begin
                // Read and write together is treated as a write.
                mif.bus_addr  <= mif.d_addr;
                mif.bus_wdata <= mif.d_wdata;
                mif.bus_ben   <= mif.d_write ? mif.d_ben : 4'hF;
                mif.bus_wen   <= mif.d_write;
                mif.bus_ren   <= ~mif.d_write;
            end else if (start_i) begin
                mif.bus_addr  <= mif.i_addr;
                mif.bus_wdata <= '0;
                mif.bus_ben   <= 4'hF;
                mif.bus_wen   <= 1'b0;
                mif.bus_ren   <= 1'b1;
            end
            if (done || abort) begin
                mif.bus_ren <= 1'b0;
                mif.bus_wen <= 1'b0;
                mif.err     <= abort;
                if (state == FETCH) begin
                    mif.i_ready <= 1'b1;
                    mif.i_rdata <= abort ? 32'h0 : mif.bus_rdata;
                end else begin
                    mif.d_ready <= 1'b1;
                    // The write strobe still marks the access kind here.
                    if (!mif.bus_wen)
                        mif.d_rdata <= abort ? 32'h0 : mif.bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single-access vectors plus
// hand-written sequences for data priority and reset during an access.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if mif();

    mem_arbiter #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    typedef struct {
        logic        is_i;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        int          busy;
        logic [31:0] rdata;
        logic        e_wen;
        logic [3:0]  e_ben;
        int          e_strobes;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[8];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic drive_idle();
        mif.i_req   = 1'b0;
        mif.d_read  = 1'b0;
        mif.d_write = 1'b0;
    endtask

    initial begin
        int  strobes;
        bit  got;

        mif.i_req     = 1'b0;
        mif.i_addr    = '0;
        mif.d_read    = 1'b0;
        mif.d_write   = 1'b0;
        mif.d_addr    = '0;
        mif.d_wdata   = '0;
        mif.d_ben     = '0;
        mif.bus_rdata = '0;
        mif.bus_busy  = 1'b0;

        //            is_i  rd    wr    addr          wdata         ben   busy rdata         e_wen e_ben strb e_rdata       e_err
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0,        4'h0, 0,  32'h3E80_0093, 1'b0, 4'hF, 1, 32'h3E80_0093, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 0,  32'hDEAD_BEEF, 1'b0, 4'hF, 1, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 3,  32'hAAAA_5555, 1'b1, 4'h3, 4, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0,        4'h0, 99, 32'h1111_1111, 1'b0, 4'hF, 4, 32'h0,         1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hC, 1,  32'h7777_7777, 1'b1, 4'hC, 2, 32'h0,         1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,        4'h0, 2,  32'h0000_0013, 1'b0, 4'hF, 3, 32'h0000_0013, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0,        4'h0, 99, 32'h2222_2222, 1'b0, 4'hF, 4, 32'h0,         1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 1,  32'h0BAD_F00D, 1'b0, 4'hF, 2, 32'h0BAD_F00D, 1'b0};

        // Reset state
        #2;
        check("rst_bus_strobes", 32'({mif.bus_ren, mif.bus_wen}), 32'h0);
        check("rst_bus_addr",    mif.bus_addr, 32'h0);
        check("rst_bus_ben",     32'(mif.bus_ben), 32'h0);
        check("rst_pulses",      32'({mif.i_ready, mif.d_ready, mif.err}), 32'h0);
        check("rst_rdata",       mif.i_rdata | mif.d_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single-access vectors
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            mif.i_req     = vecs[v].is_i;
            mif.i_addr    = vecs[v].addr;
            mif.d_read    = vecs[v].rd;
            mif.d_write   = vecs[v].wr;
            mif.d_addr    = vecs[v].addr;
            mif.d_wdata   = vecs[v].wdata;
            mif.d_ben     = vecs[v].ben;
            mif.bus_rdata = vecs[v].rdata;
            mif.bus_busy  = 1'b0;
            #1;
            check($sformatf("v%0d_freeze_req", v), 32'(mif.freeze), 32'h1);
            strobes = 0;
            got     = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (mif.i_ready || mif.d_ready) begin
                    got = 1'b1;
                    break;
                end
                strobes++;
                check($sformatf("v%0d_c%0d_strobe", v, c), 32'({mif.bus_ren, mif.bus_wen}),
                      32'({~vecs[v].e_wen, vecs[v].e_wen}));
                check($sformatf("v%0d_c%0d_addr", v, c), mif.bus_addr, vecs[v].addr);
                check($sformatf("v%0d_c%0d_ben", v, c), 32'(mif.bus_ben), 32'(vecs[v].e_ben));
                if (vecs[v].e_wen)
                    check($sformatf("v%0d_c%0d_wdata", v, c), mif.bus_wdata, vecs[v].wdata);
                check($sformatf("v%0d_c%0d_freeze", v, c), 32'(mif.freeze), 32'h1);
                mif.bus_busy = (c < vecs[v].busy);
            end
            mif.bus_busy = 1'b0;
            check($sformatf("v%0d_ready_seen", v), 32'(got), 32'h1);
            check($sformatf("v%0d_strobe_cycles", v), 32'(strobes), 32'(vecs[v].e_strobes));
            check($sformatf("v%0d_ready_kind", v), 32'({mif.i_ready, mif.d_ready}),
                  32'({vecs[v].is_i, ~vecs[v].is_i}));
            check($sformatf("v%0d_rdata", v), vecs[v].is_i ? mif.i_rdata : mif.d_rdata, vecs[v].e_rdata);
            check($sformatf("v%0d_err", v), 32'(mif.err), 32'(vecs[v].e_err));
            check($sformatf("v%0d_freeze_ready", v), 32'(mif.freeze), 32'h0);
            check($sformatf("v%0d_strobes_off", v), 32'({mif.bus_ren, mif.bus_wen}), 32'h0);
            drive_idle();
            @(negedge clk);
            check($sformatf("v%0d_pulses_end", v), 32'({mif.i_ready, mif.d_ready, mif.err}), 32'h0);
        end

        // Data request wins over a simultaneous fetch; fetch follows
        @(negedge clk);
        mif.i_req     = 1'b1;
        mif.i_addr    = 32'h0000_0040;
        mif.d_read    = 1'b1;
        mif.d_addr    = 32'h0000_0100;
        mif.bus_rdata = 32'hDEAD_BEEF;
        mif.bus_busy  = 1'b0;
        @(negedge clk);
        check("prio_data_addr", mif.bus_addr, 32'h0000_0100);
        check("prio_data_ren", 32'(mif.bus_ren), 32'h1);
        @(negedge clk);
        check("prio_d_ready", 32'({mif.i_ready, mif.d_ready}), 32'h1);
        check("prio_d_rdata", mif.d_rdata, 32'hDEAD_BEEF);
        mif.d_read = 1'b0;
        @(negedge clk);
        check("prio_fetch_addr", mif.bus_addr, 32'h0000_0040);
        check("prio_fetch_ren", 32'(mif.bus_ren), 32'h1);
        @(negedge clk);
        check("prio_i_ready", 32'({mif.i_ready, mif.d_ready}), 32'h2);
        check("prio_i_rdata", mif.i_rdata, 32'hDEAD_BEEF);
        drive_idle();
        @(negedge clk);

        // Asynchronous reset during the second busy cycle of a fetch
        mif.i_req     = 1'b1;
        mif.i_addr    = 32'h0000_0020;
        mif.bus_rdata = 32'h0000_0055;
        mif.bus_busy  = 1'b1;
        @(negedge clk);
        check("rstmid_ren_before", 32'(mif.bus_ren), 32'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_ren_drop", 32'(mif.bus_ren), 32'h0);
        check("rstmid_addr", mif.bus_addr, 32'h0);
        check("rstmid_d_rdata", mif.d_rdata, 32'h0);
        check("rstmid_pulses", 32'({mif.i_ready, mif.d_ready, mif.err}), 32'h0);
        @(negedge clk);
        check("rstmid_no_ready", 32'(mif.i_ready), 32'h0);
        rst          = 1'b0;
        mif.bus_busy = 1'b0;
        @(negedge clk);
        check("rstmid_restart_ren", 32'(mif.bus_ren), 32'h1);
        check("rstmid_restart_addr", mif.bus_addr, 32'h0000_0020);
        @(negedge clk);
        check("rstmid_restart_ready", 32'(mif.i_ready), 32'h1);
        check("rstmid_restart_rdata", mif.i_rdata, 32'h0000_0055);
        drive_idle();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-cycle core's one memory port between instruction fetch and data load/store.
- Sequences each access through an FSM and honours bus wait states.
- Drives a freeze signal that holds the PC and register-file write while an access is outstanding.
- Sits between the fetch/PC logic, the control unit's memRead/memWrite outputs, and the external RAM bus.

Parameters:
- TIMEOUT, 255: maximum cycles an access may wait on bus_busy before it is aborted (1..65535).
- CNT_W, 16: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction fetch request, level.
- i_addr  in  32  fetch address.
- i_rdata  out  32  fetched instruction, registered.
- i_ready  out  1  one-cycle pulse: fetch complete.
- d_read  in  1  data read request (control memRead), level.
- d_write  in  1  data write request (control memWrite), level.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ben  in  4  store byte enables.
- d_rdata  out  32  load data, registered.
- d_ready  out  1  one-cycle pulse: data access complete.
- bus_addr  out  32  memory address, registered.
- bus_wdata  out  32  memory write data, registered.
- bus_ben  out  4  byte enables: d_ben for writes, 4'hF for reads and fetches.
- bus_ren  out  1  memory read strobe, registered.
- bus_wen  out  1  memory write strobe, registered.
- bus_rdata  in  32  memory read data.
- bus_busy  in  1  memory wait; high means the access has not completed.
- freeze  out  1  stall PC and writeback, combinational.
- err  out  1  one-cycle pulse: access aborted by timeout.

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, counter=0.
  - All bus_* outputs, i_rdata, d_rdata = 0.
  - i_ready, d_ready, err = 0.
  - Reset mid-access drops the strobes at once; the access is abandoned with no ready pulse.
- FSM states: IDLE, FETCH, DATA.
- IDLE transitions:
  - Data request pending (d_read|d_write) and d_ready=0 -> DATA. Data has priority: it belongs to the current instruction.
  - Otherwise i_req and i_ready=0 -> FETCH.
  - Otherwise stay in IDLE.
  - A requester whose ready is high this cycle is ignored, so the same request is never reissued.
- Bus outputs load on the IDLE->access edge and hold stable for the whole access:
  - bus_addr = i_addr or d_addr.
  - bus_wdata = d_wdata.
  - bus_wen = d_write; bus_ren = !d_write.
  - d_read and d_write both high is treated as a write.
- In FETCH or DATA, each cycle:
  - bus_busy=0: on the next edge, capture bus_rdata into i_rdata (FETCH) or d_rdata (DATA read; a write leaves d_rdata unchanged). Pulse the matching ready for exactly one cycle, clear strobes and counter, return to IDLE.
  - bus_busy=1: counter increments.
  - counter==TIMEOUT-1 with bus_busy=1: abort. Strobes clear, matching ready pulses, captured data=0, err pulses with it, return to IDLE.
- Latency:
  - Request in cycle N -> strobe in N+1 -> ready in N+2 with zero wait states.
  - Each busy cycle adds one cycle.
  - Back-to-back: a data request becomes eligible again in the cycle after its d_ready.
- freeze = ((d_read|d_write) & !d_ready) | (i_req & !i_ready).
  - Low in the ready cycle, so the PC advances exactly once per access.
- Request inputs are sampled only in IDLE; changes during an access are ignored until IDLE.
- Counter saturates and never wraps; it clears on every return to IDLE.

Test Plan:
1. Zero-wait fetch:
   - Stimulus: i_req=1, i_addr=0x0000_0004, bus_busy=0, bus_rdata=0x3E80_0093.
   - Response: bus_ren=1 at cycle 1; i_ready=1 and i_rdata=0x3E80_0093 at cycle 2; freeze high in cycles 0-1, low in cycle 2.
2. Data priority:
   - Stimulus: i_req=1 and d_read=1 (d_addr=0x100) in the same cycle, bus_rdata=0xDEAD_BEEF.
   - Response: the DATA access is issued first (bus_addr=0x100); d_ready with d_rdata=0xDEAD_BEEF; FETCH issues on the following cycle.
3. Write with 3 wait states:
   - Stimulus: d_write=1, d_addr=0x200, d_wdata=0x1234_5678, d_ben=4'b0011, bus_busy high for 3 cycles.
   - Response: bus_wen/bus_ben/bus_wdata stable for 4 cycles; d_ready at cycle 5; d_rdata unchanged.
4. Timeout:
   - Stimulus: TIMEOUT=4, d_read=1, bus_busy held at 1.
   - Response: strobe high for 4 cycles; then d_ready=1, err=1, d_rdata=0; FSM returns to IDLE.
5. Reset mid-access:
   - Stimulus: assert rst asynchronously during the second busy cycle of a fetch.
   - Response: bus_ren=0 immediately; no i_ready; all outputs 0; the fetch restarts cleanly after deassert.
6. Illegal read+write:
   - Stimulus: d_read=1 and d_write=1.
   - Response: bus_wen=1, bus_ren=0; one d_ready pulse.
